// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, taken-branch flush, multi-cycle multiply freeze.
// Latency: all control outputs are combinational from current state and inputs; state updates on the Clk rising edge.
// Backpressure: stalls upstream by dropping PCWrite/IFID_Write; freezes ID/EX for MUL_LAT cycles on a multiply.
module pipeline_hazard_ctrl #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [4:0]  IFID_rs,
   input  logic [4:0]  IFID_rt,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_rt,
   input  logic        Mul_start,
   input  logic        Branch_taken,
   output logic        PCWrite,
   output logic        IFID_Write,
   output logic        IFID_Flush,
   output logic        IDEX_Write,
   output logic        IDEX_Bubble,
   output logic        EXMEM_Bubble,
   output logic        MulBusy,
   output logic [15:0] StallCount
);

   typedef enum logic {RUN, MUL_WAIT} state_t;

   // The Mul_start cycle is the first frozen cycle, so the counter covers the remaining MUL_LAT-1.
   localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] mul_cnt;
   logic [3:0] mul_cnt_nxt;
   logic       load_use;

   // Register zero is never a real destination, so a load to r0 cannot create a hazard.
   assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                     ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));

   // State and multiply counter registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= RUN;
         mul_cnt <= 4'd0;
      end else begin
         state   <= state_nxt;
         mul_cnt <= mul_cnt_nxt;
      end
   end

   // Next-state and output decode; reset outputs override everything while Rst is high.
   always_comb begin
      state_nxt    = state;
      mul_cnt_nxt  = mul_cnt;
      PCWrite      = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Write   = 1'b1;
      IDEX_Bubble  = 1'b0;
      EXMEM_Bubble = 1'b0;
      MulBusy      = 1'b0;
      if (Rst) begin
         state_nxt    = RUN;
         mul_cnt_nxt  = 4'd0;
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IFID_Flush   = 1'b1;
         IDEX_Write   = 1'b0;
         IDEX_Bubble  = 1'b1;
         EXMEM_Bubble = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (Mul_start) begin
                  // Freeze starts immediately, so this cycle already looks like MUL_WAIT.
                  state_nxt    = MUL_WAIT;
                  mul_cnt_nxt  = MUL_LOAD;
                  PCWrite      = 1'b0;
                  IFID_Write   = 1'b0;
                  IDEX_Write   = 1'b0;
                  EXMEM_Bubble = 1'b1;
                  MulBusy      = 1'b1;
               end else if (Branch_taken) begin
                  // Wrong-path instruction in ID is squashed; the stall it might cause is moot.
                  IFID_Flush  = 1'b1;
                  IDEX_Bubble = 1'b1;
               end else if (load_use) begin
                  PCWrite     = 1'b0;
                  IFID_Write  = 1'b0;
                  IDEX_Bubble = 1'b1;
               end
            end
            MUL_WAIT: begin
               PCWrite      = 1'b0;
               IFID_Write   = 1'b0;
               IDEX_Write   = 1'b0;
               EXMEM_Bubble = 1'b1;
               MulBusy      = 1'b1;
               if (mul_cnt <= 4'd1) begin
                  state_nxt   = RUN;
                  mul_cnt_nxt = 4'd0;
               end else begin
                  mul_cnt_nxt = mul_cnt - 4'd1;
               end
            end
            default: begin
               state_nxt   = RUN;
               mul_cnt_nxt = 4'd0;
            end
         endcase
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         StallCount <= 16'd0;
      end else if (!PCWrite && (StallCount != 16'hFFFF)) begin
         StallCount <= StallCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with the default MUL_LAT of 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected records are queued when stimulus is applied and popped at sampling time.
module tb_pipeline_hazard_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [4:0]  IFID_rs, IFID_rt, IDEX_rt;
   logic        IDEX_MemRead, Mul_start, Branch_taken;
   logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Write;
   logic        IDEX_Bubble, EXMEM_Bubble, MulBusy;
   logic [15:0] StallCount;

   pipeline_hazard_ctrl #(.MUL_LAT(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
      .Mul_start(Mul_start), .Branch_taken(Branch_taken),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble),
      .EXMEM_Bubble(EXMEM_Bubble), .MulBusy(MulBusy),
      .StallCount(StallCount)
   );

   always #5 Clk = ~Clk;

   // Output bit order: {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulBusy}
   localparam logic [6:0] O_RUN  = 7'b1101000;
   localparam logic [6:0] O_LU   = 7'b0001100;
   localparam logic [6:0] O_BR   = 7'b1111100;
   localparam logic [6:0] O_MUL  = 7'b0000011;
   localparam logic [6:0] O_RST  = 7'b0010110;

   typedef struct {
      logic       memread;
      logic [4:0] ex_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       mul;
      logic       br;
   } in_t;

   typedef struct {
      in_t        in;
      logic [6:0] outs;
      string      name;
   } vec_t;

   typedef struct {
      logic [6:0]  outs;
      logic [15:0] stall;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] stall_exp = 16'd0;
   vec_t        vecs[8];

   function automatic in_t mk_in(logic m, logic [4:0] xr, logic [4:0] s, logic [4:0] t,
                                 logic ms, logic b);
      in_t r;
      r.memread = m; r.ex_rt = xr; r.rs = s; r.rt = t; r.mul = ms; r.br = b;
      return r;
   endfunction

   task automatic apply(input in_t in);
      IDEX_MemRead = in.memread;
      IDEX_rt      = in.ex_rt;
      IFID_rs      = in.rs;
      IFID_rt      = in.rt;
      Mul_start    = in.mul;
      Branch_taken = in.br;
   endtask

   task automatic push_exp(input logic [6:0] o, input string nm);
      exp_t e;
      e.outs = o; e.stall = stall_exp; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic check_now();
      exp_t       e;
      logic [6:0] got;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL sb_empty: no expected record queued");
         return;
      end
      e   = exp_q.pop_front();
      got = {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulBusy};
      if (got !== e.outs) begin
         failures++;
         $display("FAIL %s outs: got=%b expected=%b", e.name, got, e.outs);
      end
      checks++;
      if (StallCount !== e.stall) begin
         failures++;
         $display("FAIL %s StallCount: got=%0d expected=%0d", e.name, StallCount, e.stall);
      end
   endtask

   // Called at posedge+1: drive, sample at negedge, advance the stall model, move to next posedge+1.
   task automatic run_cycle(input in_t in, input logic [6:0] o, input string nm);
      apply(in);
      push_exp(o, nm);
      @(negedge Clk);
      check_now();
      if (o[6] == 1'b0 && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
      @(posedge Clk);
      #1;
   endtask

   in_t zero_in, lu_in, mul_in, br_in;

   initial begin
      zero_in = mk_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      lu_in   = mk_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      mul_in  = mk_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      br_in   = mk_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);

      vecs[0] = '{mk_in(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0), O_RUN, "idle"};
      vecs[1] = '{mk_in(1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0), O_LU,  "lu_rs"};
      vecs[2] = '{mk_in(1'b1, 5'd7,  5'd2,  5'd7,  1'b0, 1'b0), O_LU,  "lu_rt"};
      vecs[3] = '{mk_in(1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0), O_RUN, "reg_zero"};
      vecs[4] = '{mk_in(1'b0, 5'd5,  5'd5,  5'd5,  1'b0, 1'b0), O_RUN, "no_memread"};
      vecs[5] = '{mk_in(1'b1, 5'd3,  5'd4,  5'd5,  1'b0, 1'b0), O_RUN, "no_match"};
      vecs[6] = '{mk_in(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1), O_BR,  "branch"};
      vecs[7] = '{mk_in(1'b1, 5'd9,  5'd9,  5'd9,  1'b0, 1'b1), O_BR,  "branch_over_lu"};

      // Reset state
      apply(zero_in);
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      push_exp(O_RST, "reset_hold");
      check_now();
      #2 Rst = 1'b0;
      run_cycle(zero_in, O_RUN, "first_after_reset");

      // Single-cycle RUN vectors
      foreach (vecs[i]) run_cycle(vecs[i].in, vecs[i].outs, vecs[i].name);

      // Load-use lasts one cycle only; stall count from the table is 2 so far
      run_cycle(lu_in,   O_LU,  "lu_once");
      run_cycle(zero_in, O_RUN, "lu_released");

      // Multiply: 4 frozen cycles, branch and load-use ignored while waiting
      run_cycle(mul_in, O_MUL, "mul_c0");
      run_cycle(br_in,  O_MUL, "mul_c1_br_ignored");
      run_cycle(mk_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1), O_MUL, "mul_c2_lu_br_ignored");
      run_cycle(mul_in, O_MUL, "mul_c3_mul_ignored");
      run_cycle(zero_in, O_RUN, "mul_done");
      run_cycle(br_in,   O_BR,  "branch_after_mul");

      // Mul_start outranks branch and load-use
      run_cycle(mk_in(1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1), O_MUL, "mul_prio_c0");
      repeat (3) run_cycle(zero_in, O_MUL, "mul_prio_wait");
      run_cycle(zero_in, O_RUN, "mul_prio_done");

      // Reset in the 2nd MUL_WAIT cycle, between edges
      run_cycle(mul_in,  O_MUL, "rmul_c0");
      run_cycle(zero_in, O_MUL, "rmul_c1");
      apply(zero_in);
      #2 Rst = 1'b1;
      #1;
      stall_exp = 16'd0;
      push_exp(O_RST, "reset_mid_mul");
      check_now();
      @(posedge Clk);
      #1;
      push_exp(O_RST, "reset_mid_mul_held");
      check_now();
      #2 Rst = 1'b0;
      run_cycle(zero_in, O_RUN, "after_mid_reset");
      run_cycle(zero_in, O_RUN, "after_mid_reset_2");

      // Saturation: hold a load-use match for 70000 cycles
      apply(lu_in);
      repeat (70000) @(posedge Clk);
      #1;
      stall_exp = 16'hFFFF;
      run_cycle(lu_in, O_LU, "sat_hold");
      run_cycle(lu_in, O_LU, "sat_hold_2");
      run_cycle(zero_in, O_RUN, "sat_release");

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_leftover: got=%0d records expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: total EX-stage occupancy in cycles of a multi-cycle multiply; legal range 2..15.
REQ-002 Clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 IFID_rs  in  5  rs field of the instruction in ID.
REQ-005 IFID_rt  in  5  rt field of the instruction in ID.
REQ-006 IDEX_MemRead  in  1  the instruction in EX is a load.
REQ-007 IDEX_rt  in  5  destination register of the instruction in EX.
REQ-008 Mul_start  in  1  a multiply entered EX this cycle.
REQ-009 Branch_taken  in  1  a branch resolved taken in EX this cycle.
REQ-010 PCWrite  out  1  enable for the PC register.
REQ-011 IFID_Write  out  1  enable for the IF/ID register.
REQ-012 IFID_Flush  out  1  clears IF/ID to a NOP on the next edge.
REQ-013 IDEX_Write  out  1  enable for the ID/EX register.
REQ-014 IDEX_Bubble  out  1  loads zeroed control fields into ID/EX on the next edge.
REQ-015 EXMEM_Bubble  out  1  loads zeroed control fields into EX/MEM on the next edge.
REQ-016 MulBusy  out  1  high while in MUL_WAIT.
REQ-017 StallCount  out  16  count of cycles in which PCWrite was 0, saturating.

Function
REQ-018 The FSM SHALL have exactly two states: RUN and MUL_WAIT; a 4-bit down-counter MulCnt; outputs combinational from state and inputs.
REQ-019 RUN defaults: PCWrite=1, IFID_Write=1, IDEX_Write=1; IFID_Flush, IDEX_Bubble and EXMEM_Bubble=0.
REQ-020 Load-use hazard: IDEX_MemRead=1, IDEX_rt!=0 and (IDEX_rt==IFID_rs or IDEX_rt==IFID_rt). In RUN this SHALL drive PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for that cycle only; no state change.
REQ-021 Branch_taken in RUN SHALL drive IFID_Flush=1 and IDEX_Bubble=1 with PCWrite=1. Branch SHALL take priority over load-use; no stall is produced.
REQ-022 Mul_start in RUN SHALL move the FSM to MUL_WAIT and load MulCnt=MUL_LAT-1. Priority: Mul_start, then Branch_taken, then load-use; lower-priority responses are suppressed.
REQ-023 On the Mul_start cycle the outputs SHALL equal the MUL_WAIT outputs.
REQ-024 MUL_WAIT outputs: PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1, MulBusy=1, others 0.
REQ-025 MUL_WAIT counting: MulCnt SHALL decrement each cycle. When MulCnt==1, return to RUN on the next edge, so the freeze lasts exactly MUL_LAT cycles including the Mul_start cycle.
REQ-026 Branch_taken, Mul_start and the load-use condition SHALL be ignored while in MUL_WAIT.
REQ-027 StallCount SHALL increment on every edge where PCWrite==0 and SHALL hold at 16'hFFFF.

Reset
REQ-028 Rst=1 SHALL immediately force state=RUN, MulCnt=0 and StallCount=0, independent of Clk, including in mid-MUL_WAIT.
REQ-029 While Rst=1, outputs SHALL be: PCWrite=0, IFID_Write=0, IDEX_Write=0, IFID_Flush=1, IDEX_Bubble=1, EXMEM_Bubble=1, MulBusy=0.
REQ-030 The first edge after Rst falls SHALL see RUN defaults.

Verification
REQ-031 Load-use check: IDEX_MemRead=1, IDEX_rt=5, IFID_rs=5 for one cycle -> PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for that cycle only; StallCount=1.
REQ-032 Register-zero check: same stimulus with IDEX_rt=0 and IFID_rt=0 -> no stall, all RUN defaults.
REQ-033 Branch/load-use overlap: Branch_taken=1 together with a load-use match -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; StallCount unchanged.
REQ-034 Multiply stall: MUL_LAT=4, Mul_start pulse -> PCWrite=0 and MulBusy=1 for exactly 4 cycles, then RUN. Branch_taken asserted during the wait is ignored; StallCount=4.
REQ-035 Reset mid-multiply: Rst asserted in the 2nd MUL_WAIT cycle between edges -> MulBusy falls at once and the REQ-029 reset outputs apply. After release: RUN, StallCount=0.
REQ-036 Counter saturation: hold a load-use match for 70000 cycles -> StallCount stops at 16'hFFFF.
